// File: rtl/dpc_pkg.sv
// Shared definitions for the bad-point LUT path: FSM encoding, LUT entry
// format and the sentinel used to mark unused table slots.
package dpc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } bp_state_e;

  localparam logic [31:0] BP_SENTINEL = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } bp_entry_t;

  function automatic logic [31:0] bp_pack(input logic [15:0] x, input logic [15:0] y);
    return {x, y};
  endfunction

  function automatic bp_entry_t bp_unpack(input logic [31:0] word);
    return bp_entry_t'(word);
  endfunction

endpackage

// File: rtl/bad_point_lut_ctrl_if.sv
// Host, auto-detector, frame-timing and LUT write-port signals of the
// bad-point LUT controller.
interface bad_point_lut_ctrl_if #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 10,
  parameter int MAX_DP_BIT  = 7
);
  logic                   frame_start;
  logic                   frame_active;
  logic                   host_valid;
  logic                   host_ready;
  logic [MAX_DP_BIT-1:0]  host_addr;
  logic [31:0]            host_data;
  logic                   host_num_valid;
  logic [MAX_DP_BIT-1:0]  host_num;
  logic                   clear_req;
  logic                   auto_valid;
  logic                   auto_ready;
  logic [WIDTH_BITS-1:0]  auto_x;
  logic [HEIGHT_BITS-1:0] auto_y;
  logic                   wen_lut;
  logic [MAX_DP_BIT-1:0]  waddr_lut;
  logic [31:0]            wdata_lut;
  logic [MAX_DP_BIT-1:0]  bad_point_num;
  logic [MAX_DP_BIT-1:0]  pending_num;
  logic                   table_full;
  logic                   overflow;
  logic                   busy;

  modport slave (
    input  frame_start, frame_active,
    input  host_valid, host_addr, host_data, host_num_valid, host_num, clear_req,
    input  auto_valid, auto_x, auto_y,
    output host_ready, auto_ready,
    output wen_lut, waddr_lut, wdata_lut,
    output bad_point_num, pending_num, table_full, overflow, busy
  );

  modport master (
    output frame_start, frame_active,
    output host_valid, host_addr, host_data, host_num_valid, host_num, clear_req,
    output auto_valid, auto_x, auto_y,
    input  host_ready, auto_ready,
    input  wen_lut, waddr_lut, wdata_lut,
    input  bad_point_num, pending_num, table_full, overflow, busy
  );
endinterface

// File: rtl/bp_auto_fifo.sv
// Synchronous FIFO buffering auto-detected coordinates until blanking.
// A flush empties the queue but still accepts a push in the same cycle.
module bp_auto_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // NOTE: the payload array has no reset; pointers alone define validity,
  // so resetting storage would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (flush_i) begin
        rd_ptr_q <= wr_ptr_q;
        count_q  <= {{PTR_W{1'b0}}, do_push};
      end else begin
        if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
      end
    end
  end

endmodule

// File: rtl/bad_point_lut_ctrl.sv
// Write-side arbiter for the bad-point LUT: host writes, buffered auto appends
// drained in blanking, table wipe, and frame-synchronous length commit.
module bad_point_lut_ctrl
  import dpc_pkg::*;
#(
  parameter int WIDTH_BITS      = 10,
  parameter int HEIGHT_BITS     = 10,
  parameter int MAX_DP_NUM      = 128,
  parameter int MAX_DP_BIT      = 7,
  parameter int AUTO_FIFO_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  bad_point_lut_ctrl_if.slave bus
);
  localparam int ENTRY_W = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [MAX_DP_BIT-1:0] LAST_IDX = MAX_DP_BIT'(MAX_DP_NUM - 1);

  bp_state_e             state_q, state_d;
  logic [MAX_DP_BIT-1:0] clr_cnt_q, clr_cnt_d;
  logic [MAX_DP_BIT-1:0] pending_q, pending_d;
  logic [MAX_DP_BIT-1:0] bad_num_q, bad_num_d;
  logic [MAX_DP_BIT-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic                  overflow_q, overflow_d;
  logic                  clear_pend_q, clear_pend_d;
  logic                  fs_q;

  logic                   fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]     fifo_dout;
  logic [WIDTH_BITS-1:0]  pop_x;
  logic [HEIGHT_BITS-1:0] pop_y;
  logic                   fs_rise, blank, host_wr, enter_clr, num_set, pop, drop;

  assign fs_rise   = bus.frame_start & ~fs_q;
  assign blank     = (state_q == ST_IDLE) & ~bus.frame_active;
  assign host_wr   = blank & bus.host_valid;
  assign enter_clr = blank & ~bus.host_valid & clear_pend_q;
  assign num_set   = (state_q == ST_IDLE) & bus.host_num_valid & ~enter_clr;
  // A pending length update outranks a drain; the entry stays queued.
  assign pop       = blank & ~bus.host_valid & ~clear_pend_q & ~bus.host_num_valid & ~fifo_empty;
  assign drop      = bus.auto_valid & fifo_full;
  assign {pop_x, pop_y} = fifo_dout;

  bp_auto_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (AUTO_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (enter_clr),
    .push_i  (bus.auto_valid),
    .din_i   ({bus.auto_x, bus.auto_y}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    clear_pend_d = clear_pend_q | bus.clear_req;
    wen_d        = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    bad_num_d    = fs_rise ? pending_q : bad_num_q;

    unique case (state_q)
      ST_IDLE: begin
        if (host_wr) begin
          wen_d   = 1'b1;
          waddr_d = bus.host_addr;
          wdata_d = bus.host_data;
        end
        if (enter_clr) begin
          state_d      = ST_CLEAR;
          clr_cnt_d    = '0;
          pending_d    = '0;
          overflow_d   = 1'b0;
          clear_pend_d = bus.clear_req;
        end else if (num_set) begin
          pending_d = (bus.host_num > LAST_IDX) ? LAST_IDX : bus.host_num;
        end else if (pop) begin
          if (pending_q == LAST_IDX) begin
            overflow_d = 1'b1;
          end else begin
            wen_d     = 1'b1;
            waddr_d   = pending_q;
            wdata_d   = bp_pack(16'(pop_x), 16'(pop_y));
            pending_d = pending_q + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        wen_d     = 1'b1;
        waddr_d   = clr_cnt_q;
        wdata_d   = BP_SENTINEL;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = ST_IDLE;
      end
    endcase

    if (drop) overflow_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      pending_q    <= '0;
      bad_num_q    <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      overflow_q   <= 1'b0;
      clear_pend_q <= 1'b0;
      fs_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      pending_q    <= pending_d;
      bad_num_q    <= bad_num_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
      overflow_q   <= overflow_d;
      clear_pend_q <= clear_pend_d;
      fs_q         <= bus.frame_start;
    end
  end

  assign bus.host_ready    = rst_n & blank;
  assign bus.auto_ready    = ~fifo_full;
  assign bus.wen_lut       = wen_q;
  assign bus.waddr_lut     = waddr_q;
  assign bus.wdata_lut     = wdata_q;
  assign bus.bad_point_num = bad_num_q;
  assign bus.pending_num   = pending_q;
  assign bus.table_full    = (pending_q == LAST_IDX);
  assign bus.overflow      = overflow_q;
  assign bus.busy          = (state_q == ST_CLEAR) | ~fifo_empty;

endmodule

// File: tb/tb_bad_point_lut_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based behavioural model of the LUT controller.
module tb_bad_point_lut_ctrl;
  localparam int W    = 10;
  localparam int H    = 10;
  localparam int N    = 128;
  localparam int AB   = 7;
  localparam int FD   = 16;
  localparam int LAST = N - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bad_point_lut_ctrl_if #(.WIDTH_BITS(W), .HEIGHT_BITS(H), .MAX_DP_BIT(AB)) bus ();

  bad_point_lut_ctrl #(
    .WIDTH_BITS      (W),
    .HEIGHT_BITS     (H),
    .MAX_DP_NUM      (N),
    .MAX_DP_BIT      (AB),
    .AUTO_FIFO_DEPTH (FD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Behavioural model: table length, a plain queue for the auto buffer and a
  // count of sentinel writes still owed by a wipe.
  int          m_pending    = 0;
  int          m_bad        = 0;
  int          m_clear_left = 0;
  int          m_waddr      = 0;
  bit          m_ovf        = 1'b0;
  bit          m_clear_pend = 1'b0;
  bit          m_fs_prev    = 1'b1;
  bit          m_wen        = 1'b0;
  logic [31:0] m_wdata      = '0;
  logic [31:0] m_fifo [$];

  task automatic model_step();
    bit          fs_rise, full_now, blank;
    int          new_bad;
    logic [31:0] e;
    fs_rise   = bus.frame_start && !m_fs_prev;
    m_fs_prev = bus.frame_start;
    new_bad   = fs_rise ? m_pending : m_bad;
    full_now  = (m_fifo.size() == FD);
    m_wen     = 1'b0;
    if (m_clear_left > 0) begin
      m_wen   = 1'b1;
      m_waddr = N - m_clear_left;
      m_wdata = 32'hFFFF_FFFF;
      m_clear_left--;
    end else begin
      blank = !bus.frame_active;
      if (blank && bus.host_valid) begin
        m_wen   = 1'b1;
        m_waddr = int'(bus.host_addr);
        m_wdata = bus.host_data;
      end
      if (blank && !bus.host_valid && m_clear_pend) begin
        m_clear_left = N;
        m_pending    = 0;
        m_fifo.delete();
        m_ovf        = 1'b0;
        m_clear_pend = 1'b0;
      end else if (bus.host_num_valid) begin
        m_pending = (int'(bus.host_num) > LAST) ? LAST : int'(bus.host_num);
      end else if (blank && !bus.host_valid && m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        if (m_pending == LAST) m_ovf = 1'b1;
        else begin
          m_wen   = 1'b1;
          m_waddr = m_pending;
          m_wdata = e;
          m_pending++;
        end
      end
    end
    if (bus.clear_req) m_clear_pend = 1'b1;
    if (bus.auto_valid && !full_now) m_fifo.push_back({16'(bus.auto_x), 16'(bus.auto_y)});
    if (bus.auto_valid && full_now) m_ovf = 1'b1;
    m_bad = new_bad;
  endtask

  always @(posedge clk) begin
    cyc_cnt++;
    if (!rst_n) begin
      m_pending = 0; m_bad = 0; m_clear_left = 0; m_waddr = 0;
      m_ovf = 1'b0; m_clear_pend = 1'b0; m_fs_prev = 1'b1; m_wen = 1'b0; m_wdata = '0;
      m_fifo.delete();
    end else begin
      model_step();
    end
  end

  // Observed LUT writes, for the directed checks on ordering and spacing.
  logic [AB-1:0] log_addr [$];
  logic [31:0]   log_data [$];
  int            log_cyc  [$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("wen_lut", 32'(bus.wen_lut), 32'(m_wen));
      if (m_wen) begin
        check("waddr_lut", 32'(bus.waddr_lut), m_waddr);
        check("wdata_lut", bus.wdata_lut, m_wdata);
      end
      check("pending_num", 32'(bus.pending_num), m_pending);
      check("bad_point_num", 32'(bus.bad_point_num), m_bad);
      check("table_full", 32'(bus.table_full), 32'(m_pending == LAST));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("busy", 32'(bus.busy), 32'((m_clear_left > 0) || (m_fifo.size() > 0)));
      check("host_ready", 32'(bus.host_ready), 32'((m_clear_left == 0) && !bus.frame_active));
      check("auto_ready", 32'(bus.auto_ready), 32'(m_fifo.size() < FD));
      if (bus.wen_lut) begin
        log_addr.push_back(bus.waddr_lut);
        log_data.push_back(bus.wdata_lut);
        log_cyc.push_back(cyc_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  localparam logic [31:0] S2_DATA [3] = '{32'h000B_0015, 32'h000C_0016, 32'h000D_0017};

  initial begin
    int base;
    rst_n = 1'b0;
    bus.frame_start = 1'b0; bus.frame_active = 1'b0;
    bus.host_valid = 1'b0; bus.host_addr = '0; bus.host_data = '0;
    bus.host_num_valid = 1'b0; bus.host_num = '0; bus.clear_req = 1'b0;
    bus.auto_valid = 1'b0; bus.auto_x = '0; bus.auto_y = '0;
    tick_n(3);

    @(negedge clk);
    check("rst_wen", 32'(bus.wen_lut), 0);
    check("rst_waddr", 32'(bus.waddr_lut), 0);
    check("rst_wdata", bus.wdata_lut, 0);
    check("rst_bad_num", 32'(bus.bad_point_num), 0);
    check("rst_pending", 32'(bus.pending_num), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_table_full", 32'(bus.table_full), 0);
    check("rst_host_ready", 32'(bus.host_ready), 0);
    check("rst_auto_ready", 32'(bus.auto_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Host loads two entries in blanking, sets length 2, then frame start.
    bus.host_valid = 1'b1; bus.host_addr = 7'd0; bus.host_data = 32'h0005_0003;
    tick();
    bus.host_addr = 7'd1; bus.host_data = 32'h0009_0003;
    @(negedge clk);
    check("s1_wr0_en", 32'(bus.wen_lut), 1);
    check("s1_wr0_addr", 32'(bus.waddr_lut), 0);
    check("s1_wr0_data", bus.wdata_lut, 32'h0005_0003);
    tick();
    bus.host_valid = 1'b0; bus.host_num_valid = 1'b1; bus.host_num = 7'd2;
    @(negedge clk);
    check("s1_wr1_en", 32'(bus.wen_lut), 1);
    check("s1_wr1_addr", 32'(bus.waddr_lut), 1);
    check("s1_wr1_data", bus.wdata_lut, 32'h0009_0003);
    tick();
    bus.host_num_valid = 1'b0; bus.frame_start = 1'b1;
    @(negedge clk);
    check("s1_pending", 32'(bus.pending_num), 2);
    check("s1_bad_before_edge", 32'(bus.bad_point_num), 0);
    tick();
    bus.frame_start = 1'b0;
    @(negedge clk);
    check("s1_bad_after_edge", 32'(bus.bad_point_num), 2);

    // Auto entries during active video are buffered, drained in blanking.
    tick();
    bus.frame_active = 1'b1; bus.host_num_valid = 1'b1; bus.host_num = 7'd0;
    tick();
    bus.host_num_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.auto_valid = 1'b1; bus.auto_x = W'(11 + i); bus.auto_y = H'(21 + i);
      tick();
    end
    bus.auto_valid = 1'b0;
    base = log_addr.size();
    tick_n(3);
    check("s2_no_write_active", log_addr.size(), base);
    bus.frame_active = 1'b0;
    tick_n(6);
    check("s2_write_count", log_addr.size(), base + 3);
    if (log_addr.size() == base + 3) begin
      for (int i = 0; i < 3; i++) begin
        check("s2_addr", 32'(log_addr[base+i]), i);
        check("s2_data", log_data[base+i], S2_DATA[i]);
      end
      check("s2_back_to_back", log_cyc[base+2] - log_cyc[base], 2);
    end
    check("s2_pending", 32'(bus.pending_num), 3);

    // Host write and non-empty FIFO in the same blanking cycle.
    bus.frame_active = 1'b1; bus.auto_valid = 1'b1; bus.auto_x = W'(30); bus.auto_y = H'(40);
    tick();
    bus.auto_valid = 1'b0; bus.frame_active = 1'b0;
    bus.host_valid = 1'b1; bus.host_addr = 7'd10; bus.host_data = 32'hA5A5_0001;
    base = log_addr.size();
    tick();
    bus.host_valid = 1'b0;
    tick_n(4);
    check("s3_write_count", log_addr.size(), base + 2);
    if (log_addr.size() == base + 2) begin
      check("s3_host_first", 32'(log_addr[base]), 10);
      check("s3_pop_second", 32'(log_addr[base+1]), 3);
      check("s3_pop_data", log_data[base+1], 32'h001E_0028);
      check("s3_spacing", log_cyc[base+1] - log_cyc[base], 1);
    end

    // Table full: drained entries are discarded and flagged.
    bus.host_num_valid = 1'b1; bus.host_num = 7'd127;
    tick();
    bus.host_num_valid = 1'b0; bus.frame_active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.auto_valid = 1'b1; bus.auto_x = W'(i + 1); bus.auto_y = H'(i + 1);
      tick();
    end
    bus.auto_valid = 1'b0; bus.frame_active = 1'b0;
    base = log_addr.size();
    tick_n(5);
    check("s5_no_write", log_addr.size(), base);
    check("s5_pending", 32'(bus.pending_num), 127);
    check("s5_overflow", 32'(bus.overflow), 1);
    check("s5_table_full", 32'(bus.table_full), 1);

    // Clear across a frame-start edge, with active video rising mid-wipe.
    bus.clear_req = 1'b1;
    base = log_addr.size();
    tick();
    bus.clear_req = 1'b0;
    tick();
    tick_n(10);
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0; bus.frame_active = 1'b1;
    tick_n(20);
    bus.frame_active = 1'b0;
    tick_n(110);
    check("s6_write_count", log_addr.size(), base + N);
    if (log_addr.size() == base + N) begin
      for (int i = 0; i < N; i++) begin
        check("s6_addr", 32'(log_addr[base+i]), i);
        check("s6_sentinel", log_data[base+i], 32'hFFFF_FFFF);
      end
      check("s6_no_gap", log_cyc[base+N-1] - log_cyc[base], N - 1);
    end
    check("s6_bad_num", 32'(bus.bad_point_num), 0);
    check("s6_overflow", 32'(bus.overflow), 0);
    check("s6_pending", 32'(bus.pending_num), 0);

    // FIFO overflow: 17 back-to-back pushes into a 16-deep buffer.
    bus.frame_active = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.auto_valid = 1'b1; bus.auto_x = W'(100 + i); bus.auto_y = H'(200 + i);
      if (i >= 15) begin
        @(negedge clk);
        check("s4_auto_ready", 32'(bus.auto_ready), (i == 16) ? 0 : 1);
      end
      tick();
    end
    bus.auto_valid = 1'b0;
    check("s4_overflow", 32'(bus.overflow), 1);
    bus.frame_active = 1'b0;
    tick_n(20);
    check("s4_drained", 32'(bus.pending_num), 16);

    // Random traffic with one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) bus.frame_active = ~bus.frame_active;
      if ($urandom_range(0, 59) == 0) bus.frame_start = ~bus.frame_start;
      bus.host_valid     = ($urandom_range(0, 4) == 0);
      bus.host_addr      = AB'($urandom);
      bus.host_data      = $urandom;
      bus.host_num_valid = ($urandom_range(0, 29) == 0);
      bus.host_num       = ($urandom_range(0, 1) == 1) ? AB'($urandom_range(120, 127)) : AB'($urandom);
      bus.clear_req      = ($urandom_range(0, 399) == 0);
      bus.auto_valid     = ($urandom_range(0, 2) == 0);
      bus.auto_x         = W'($urandom);
      bus.auto_y         = H'($urandom);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      tick();
    end

    bus.host_valid = 1'b0; bus.host_num_valid = 1'b0; bus.clear_req = 1'b0; bus.auto_valid = 1'b0;
    tick_n(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bad_point_lut_ctrl.md
# bad_point_lut_ctrl

Write-side controller for the bad-point LUT read by the manual bad-pixel detector. It shares the single LUT write port between two requesters: host register writes and the auto-detector's appended entries. Auto entries arriving during active video are buffered and written only during blanking. The table length is committed to the detector (`bad_point_num`) only on a frame-start edge, so the detector never sees a half-updated table.

## Interface
- `WIDTH_BITS`, default 10: x coordinate width.
- `HEIGHT_BITS`, default 10: y coordinate width.
- `MAX_DP_NUM`, default 128: LUT depth; usable capacity is MAX_DP_NUM-1 entries.
- `MAX_DP_BIT`, default 7: LUT address and count width.
- `AUTO_FIFO_DEPTH`, default 16: auto-entry buffer depth (power of two).

- `clk`  in  1: clock. The LUT write port is also clocked by `clk`.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `frame_start`  in  1: level; its rising edge marks frame begin.
- `frame_active`  in  1: high during active video.
- `host_valid` in 1 / `host_ready` out 1 / `host_addr` in MAX_DP_BIT / `host_data` in 32: host entry write.
- `host_num_valid` in 1 / `host_num` in MAX_DP_BIT: host sets the pending table length.
- `clear_req`  in  1: pulse; requests a table wipe.
- `auto_valid` in 1 / `auto_ready` out 1 / `auto_x` in WIDTH_BITS / `auto_y` in HEIGHT_BITS: detected-pixel append.
- `wen_lut` out 1 / `waddr_lut` out MAX_DP_BIT / `wdata_lut` out 32: LUT write port.
- `bad_point_num`  out  MAX_DP_BIT: committed table length.
- `pending_num`  out  MAX_DP_BIT: write pointer / pending length.
- `table_full`  out  1: `pending_num == MAX_DP_NUM-1`.
- `overflow`  out  1: sticky. Set by a dropped auto entry. Cleared by `clear_req`.
- `busy`  out  1: high in CLEAR, or while the FIFO is non-empty.

## Operation
- Entry packing: x zero-extended into [31:16], y zero-extended into [15:0].
- FSM has two states:
  - IDLE: normal arbitration.
  - CLEAR: wipe the table.
- IDLE, with `frame_active`=0: fixed priority, one LUT write per cycle.
  1. Host write: `host_ready`=1; writes `host_data` to `host_addr`.
  2. Otherwise, FIFO pop: appends at `pending_num`, then `pending_num`++.
- IDLE, with `frame_active`=1:
  - `host_ready`=0.
  - No FIFO drain.
  - Auto entries are only pushed into the FIFO.
- `auto_ready` equals FIFO not full, in any state. Auto entries are pushed regardless of `frame_active`.
  - `auto_valid && !auto_ready`: the source drops the entry; set `overflow`.
- FIFO pop while `table_full`: the entry is discarded, no LUT write occurs, and `overflow` is set.
- `host_num_valid`:
  - Sets `pending_num <= min(host_num, MAX_DP_NUM-1)`.
  - Accepted in IDLE only. Ignored in CLEAR.
  - If it coincides with a FIFO pop, `host_num` wins and the pop is held.
- `clear_req` is latched into `clear_pend`. In IDLE with `frame_active`=0 and no host write that cycle, the FSM enters CLEAR.
  - On entry: `pending_num <= 0`, FIFO flushed, `overflow <= 0`.
  - CLEAR writes sentinel 32'hFFFF_FFFF to addresses 0..MAX_DP_NUM-1, one per cycle, then returns to IDLE.
  - CLEAR runs to completion even if `frame_active` rises.
  - In CLEAR, `host_ready`=0 and auto pushes are still accepted into the FIFO.
- Commit: on a rising edge of `frame_start` (edge register resets to 1), `bad_point_num <= pending_num`. This happens in any state, including CLEAR, where it commits 0.
- Write to the same address by host and commit in the same cycle: the commit uses the pre-write `pending_num`.

## Timing
- All LUT outputs are registered. An accept or pop at cycle T produces `wen_lut`/`waddr_lut`/`wdata_lut` valid in cycle T+1, for exactly one cycle.
- The FIFO adds 0 cycles beyond the push. An entry pushed at T is poppable at T+1 if blanking.
- CLEAR lasts exactly MAX_DP_NUM cycles of `wen_lut`=1.
- `bad_point_num` updates the cycle after the sampled rising edge.
- Reset values:
  - `wen_lut` 0, `waddr_lut` 0, `wdata_lut` 0.
  - `bad_point_num` 0, `pending_num` 0.
  - `overflow` 0, `busy` 0, `table_full` 0.
  - `host_ready` 0, `auto_ready` 1.
  - FSM IDLE; `clear_pend` 0.
- Reset mid-CLEAR or mid-drain aborts immediately. The LUT contents are undefined until the next CLEAR.

## Structure
- Shared package `dpc_pkg` holds:
  - the entry pack/unpack function (x in [31:16], y in [15:0]);
  - `BP_SENTINEL` = 32'hFFFF_FFFF;
  - the FSM state encoding.
- Sub-module `bp_auto_fifo`: a synchronous FIFO, AUTO_FIFO_DEPTH x (WIDTH_BITS+HEIGHT_BITS), with full/empty flags and a flush input.

## Test plan
- Host loads, blanking: writes (addr 0,{x5,y3}), (addr 1,{x9,y3}), then `host_num`=2, then a `frame_start` edge.
  - Required: two `wen_lut` pulses one cycle after each accept.
  - Required: `bad_point_num`=2 the cycle after the edge.
- Auto during active video: 3 entries pushed with `frame_active`=1.
  - Required: no `wen_lut` while active.
  - Required: after `frame_active` falls, writes land at addr 0,1,2 on consecutive cycles; `pending_num`=3.
- Arbitration: host write and FIFO non-empty in the same blanking cycle.
  - Required: the host write is issued first; the FIFO pop follows next cycle.
- FIFO overflow: 17 back-to-back auto pushes with `frame_active`=1 and default depth 16.
  - Required: `auto_ready`=0 on the 17th push; `overflow`=1.
- Table full: `pending_num`=127, then 2 entries drained.
  - Required: no `wen_lut`; `overflow`=1; `pending_num` stays 127.
- Clear across frame start: `clear_req` in blanking, then a `frame_start` edge 10 cycles into CLEAR.
  - Required: 128 sentinel writes (addr 0..127) with no gap.
  - Required: `bad_point_num`=0 after the edge; `overflow`=0.
